// File: rtl/mult_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one external multiplier.
// Define MULT_ARB_TIMEOUT_EN to add a watchdog that aborts a stuck multiply with rsp_err.
module mult_arbiter #(
    parameter int N       = 256,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [2*N-1:0]    rsp_prod,
    output logic              rsp_err,
    output logic              mul_start,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    input  logic              mul_done,
    input  logic [2*N-1:0]    mul_prod
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_rsp_id;
    logic [N-1:0]    r_mul_a;
    logic [N-1:0]    r_mul_b;
    logic [2*N-1:0]  r_rsp_prod;
    logic [IW-1:0]   w_gnt;
    logic            w_found;
    logic            w_grant;
    logic            w_timeout;
    logic            w_done;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_gnt   = IW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    // rst gating keeps req_ready low while reset is held, even though IDLE is the reset state.
    assign w_grant = rst && (r_state == IDLE) && w_found;
    assign w_done  = (r_state == WAIT) && mul_done;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = w_grant && (w_gnt == IW'(gi));
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_rsp_err;

    assign w_timeout = (r_state == WAIT) && !mul_done && (r_wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_wd_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
            if (w_grant) begin
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_next = ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (w_done || w_timeout) w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr   <= '0;
            r_rsp_id   <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_rsp_prod <= '0;
        end else begin
            if (w_grant) begin
                r_mul_a  <= req_a[int'(w_gnt) * N +: N];
                r_mul_b  <= req_b[int'(w_gnt) * N +: N];
                r_rsp_id <= w_gnt;
            end
            if (w_done) begin
                r_rsp_prod <= mul_prod;
            end else if (w_timeout) begin
                r_rsp_prod <= '0;
            end
            // The pointer only advances once the owner's result has been consumed.
            if ((r_state == RESP) && rsp_ready) begin
                r_rr_ptr <= (r_rsp_id == IW'(NREQ - 1)) ? '0 : r_rsp_id + IW'(1);
            end
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign mul_start = (r_state == ISSUE);
    assign rsp_id    = r_rsp_id;
    assign rsp_prod  = r_rsp_prod;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed table-driven bench for mult_arbiter; the bench itself plays the shared multiplier.
module tb_mult_arbiter;
    localparam int N       = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int IW      = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [2*N-1:0]    rsp_prod;
    logic              rsp_err;
    logic              mul_start;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic              mul_done;
    logic [2*N-1:0]    mul_prod;

    mult_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_prod(mul_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        int         base_a;
        int         base_b;
        int         exp_g;
        int         dly;
    } vec_t;

    vec_t vecs [10];
    int   n_checks = 0;
    int   n_errors = 0;
    int   waited;
    logic seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] op_a(input int base, input int i);
        return N'(base + 37 * i);
    endfunction

    function automatic logic [N-1:0] op_b(input int base, input int i);
        return N'(base + 11 * i);
    endfunction

    task automatic set_ops(input int ba, input int bb);
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = op_a(ba, i);
            req_b[i*N +: N] = op_b(bb, i);
        end
    endtask

    // Called just after a posedge with the DUT in IDLE; returns just after the posedge back to IDLE.
    task automatic run_txn(input logic [3:0] mask, input int ba, input int bb,
                           input int eg, input int dly, input int hold);
        logic [N-1:0]   ea;
        logic [N-1:0]   eb;
        logic [2*N-1:0] ep;
        logic [3:0]     eready;
        ea     = op_a(ba, eg);
        eb     = op_b(bb, eg);
        ep     = 16'(ea) * 16'(eb);
        eready = 4'b0001 << eg;
        set_ops(ba, bb);
        req_valid = mask;
        @(negedge clk);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("grant", req_ready, eready);
        chk("ready_onehot", $onehot0(req_ready), 1);
        @(negedge clk);
        chk("mul_start", mul_start, 1);
        chk("mul_a", mul_a, ea);
        chk("mul_b", mul_b, eb);
        chk("busy_no_grant", req_ready, 0);
        chk("rsp_err_clear", rsp_err, 0);
        for (int c = 0; c < dly; c++) begin
            @(negedge clk);
            if (c == 0) chk("start_one_cycle", mul_start, 0);
        end
        mul_done = 1'b1;
        mul_prod = ep;
        @(negedge clk);
        mul_done = 1'b0;
        mul_prod = 16'hDEAD;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, eg);
        chk("rsp_prod", rsp_prod, ep);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_prod", rsp_prod, ep);
            chk("bp_id", rsp_id, eg);
            chk("bp_no_grant", req_ready, 0);
        end
        $display("txn mask=%b grant=%0d a=%0d b=%0d prod=%0d hold=%0d", mask, eg, ea, eb, ep, hold);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        vecs[0] = '{4'b0001, 3,   5,  0, 10};
        vecs[1] = '{4'b1111, 20,  7,  1, 2};
        vecs[2] = '{4'b1111, 9,   13, 2, 1};
        vecs[3] = '{4'b1111, 100, 3,  3, 4};
        vecs[4] = '{4'b1111, 255, 255, 0, 3};
        vecs[5] = '{4'b1111, 41,  60, 1, 5};
        vecs[6] = '{4'b0001, 17,  2,  0, 2};
        vecs[7] = '{4'b1010, 6,   90, 1, 7};
        vecs[8] = '{4'b1001, 12,  33, 3, 1};
        vecs[9] = '{4'b0110, 77,  8,  1, 6};

        rst       = 1'b0;
        req_valid = 4'b1111;
        req_a     = '1;
        req_b     = '1;
        rsp_ready = 1'b1;
        mul_done  = 1'b0;
        mul_prod  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_prod", rsp_prod, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_rsp_err", rsp_err, 0);
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Spurious mul_done while idle must not produce a response.
        mul_done = 1'b1;
        mul_prod = 16'hBEEF;
        @(negedge clk);
        chk("spur_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        mul_done = 1'b0;
        @(negedge clk);
        chk("spur_rsp_valid2", rsp_valid, 0);
        chk("spur_mul_start", mul_start, 0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 10; v++) begin
            run_txn(vecs[v].mask, vecs[v].base_a, vecs[v].base_b, vecs[v].exp_g, vecs[v].dly, 0);
        end

        // rr_ptr is 2 here: backpressure for 20 cycles with all requesters pending.
        run_txn(4'b1111, 50, 70, 2, 3, 20);

        // rr_ptr is 3: grant requester 2, then reset it while waiting on the multiplier.
        set_ops(30, 40);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("rw_grant", req_ready, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        chk("rw_id_before", rsp_id, 2);
        #1;
        rst = 1'b0;
        #1;
        chk("rw_rsp_id", rsp_id, 0);
        chk("rw_mul_a", mul_a, 0);
        chk("rw_mul_b", mul_b, 0);
        chk("rw_mul_start", mul_start, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        chk("rw_req_ready", req_ready, 0);
        chk("rw_rsp_prod", rsp_prod, 0);
        chk("rw_rsp_err", rsp_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_txn(4'b0101, 30, 40, 0, 4, 0);

        // rr_ptr is 1: requester 0 only, multiplier never answers.
        set_ops(21, 22);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("to_grant", req_ready, 4'b0001);
        @(negedge clk);
        chk("to_mul_start", mul_start, 1);
        req_valid = '0;
`ifdef MULT_ARB_TIMEOUT_EN
        waited = 0;
        while (!rsp_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("to_latency", waited, 17);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_prod", rsp_prod, 0);
`else
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("no_timeout", seen, 0);
        chk("no_timeout_err", rsp_err, 0);
        mul_done = 1'b1;
        mul_prod = 16'(op_a(21, 0)) * 16'(op_b(22, 0));
        @(negedge clk);
        mul_done = 1'b0;
        chk("late_rsp_valid", rsp_valid, 1);
        chk("late_rsp_prod", rsp_prod, 16'(op_a(21, 0)) * 16'(op_b(22, 0)));
`endif
        $display("txn mask=0001 grant=0 watchdog scenario");
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        run_txn(4'b0011, 5, 6, 1, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
